// File: rtl/rr_mux_arbiter_4_if.sv
// Bundle of requester-side and consumer-side signals around rr_mux_arbiter_4.
// Ports: in_valid/in_data0..3/in_ready (4 requesters), out_valid/out_data/out_sel/out_ready (consumer).
// Modport master = the arbiter itself; modport slave = the surrounding requesters and consumer.
interface rr_mux_arbiter_4_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  modport master (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter driving a shared 4:1 mux into one output register stage.
// Latency: accepted word appears on out_data one cycle after its in_ready cycle; one transfer per cycle.
// Backpressure: in_ready is held low while the output register is full and out_ready is low.
// Ports: clk, rst (sync, active high), bus (rr_mux_arbiter_4_if.master).
// Optional macro ARB_BURST_LOCK_EN: lets the last granted requester win up to BURST_LEN times in a row.
module rr_mux_arbiter_4 #(
  parameter int WIDTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux_arbiter_4_if.master   bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       last_grant_q, last_grant_d;

  logic             load_en;
  logic             any_vld;
  logic [1:0]       rr_winner;
  logic [1:0]       winner;
  logic [WIDTH-1:0] win_data;

  // Output register is free when empty or draining this cycle.
  assign load_en = !out_valid_q || bus.out_ready;
  assign any_vld = |bus.in_valid;

  // Scan from last_grant+1 upward with wrap. Iterating from the farthest
  // offset down lets the nearest valid requester overwrite earlier hits.
  // Offset 4 wraps to last_grant itself, so it is checked last.
  always_comb begin
    logic [1:0] idx;
    rr_winner = last_grant_q;
    idx       = last_grant_q;
    for (int i = 4; i >= 1; i--) begin
      idx = last_grant_q + 2'(i);
      if (bus.in_valid[idx]) rr_winner = idx;
    end
  end

`ifdef ARB_BURST_LOCK_EN
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       burst_hold;

  // A zero count means nobody currently owns a burst (after reset or idle),
  // so the reset value of last_grant does not get an unearned repeat.
  assign burst_hold = (burst_cnt_q != 4'd0) &&
                      (burst_cnt_q < 4'(BURST_LEN)) &&
                      bus.in_valid[last_grant_q];
  assign winner     = burst_hold ? last_grant_q : rr_winner;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (load_en) begin
      if (!any_vld)        burst_cnt_d = 4'd0;
      else if (burst_hold) burst_cnt_d = burst_cnt_q + 4'd1;
      else                 burst_cnt_d = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) burst_cnt_q <= 4'd0;
    else     burst_cnt_q <= burst_cnt_d;
  end
`else
  logic unused_burst_len;
  assign unused_burst_len = ^(4'(BURST_LEN));
  assign winner = rr_winner;
`endif

  always_comb begin
    case (winner)
      2'd0:    win_data = bus.in_data0;
      2'd1:    win_data = bus.in_data1;
      2'd2:    win_data = bus.in_data2;
      default: win_data = bus.in_data3;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      out_valid_d = any_vld;
      if (any_vld) begin
        out_data_d   = win_data;
        out_sel_d    = winner;
        last_grant_d = winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= 2'd0;
      last_grant_q <= 2'd3;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.in_ready  = (load_en && any_vld && !rst) ? (4'b0001 << winner) : 4'b0000;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
module tb_rr_mux_arbiter_4;
  localparam int W  = 4;
  localparam int BL = 2;

  logic clk;
  logic rst;
  logic [W-1:0] dat [4];
  int n_vec  = 0;
  int n_miss = 0;

  rr_mux_arbiter_4_if #(.WIDTH(W)) bus ();

  rr_mux_arbiter_4 #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.in_data0 = dat[0];
  assign bus.in_data1 = dat[1];
  assign bus.in_data2 = dat[2];
  assign bus.in_data3 = dat[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_last;
  int         m_cnt;
  logic       m_vld;
  logic [W-1:0] m_dat;
  int         m_sel;
  logic       chk_en = 1'b0;

  function automatic int m_winner();
`ifdef ARB_BURST_LOCK_EN
    if (m_cnt > 0 && m_cnt < BL && bus.in_valid[m_last]) return m_last;
`endif
    for (int d = 1; d <= 4; d++)
      if (bus.in_valid[(m_last + d) % 4]) return (m_last + d) % 4;
    return m_last;
  endfunction

  always @(posedge clk) begin : model
    int w;
    if (rst) begin
      m_vld  <= 1'b0;
      m_dat  <= '0;
      m_sel  <= 0;
      m_last <= 3;
      m_cnt  <= 0;
      chk_en <= 1'b1;
    end else if (!m_vld || bus.out_ready) begin
      if (bus.in_valid != 4'b0000) begin
        w = m_winner();
        m_vld  <= 1'b1;
        m_dat  <= dat[w];
        m_sel  <= w;
        m_last <= w;
        m_cnt  <= (w == m_last && m_cnt > 0) ? m_cnt + 1 : 1;
      end else begin
        m_vld <= 1'b0;
        m_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] exp_rdy;
    if (chk_en) begin
      exp_rdy = 4'b0000;
      if (!rst && (!m_vld || bus.out_ready) && bus.in_valid != 4'b0000)
        exp_rdy = 4'(1 << m_winner());
      chk("model in_ready",  32'(bus.in_ready),  32'(exp_rdy));
      chk("model out_valid", 32'(bus.out_valid), 32'(m_vld));
      chk("model out_data",  32'(bus.out_data),  32'(m_dat));
      chk("model out_sel",   32'(bus.out_sel),   32'(m_sel));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [3:0] v, input logic rdy, input logic r);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    rst           = r;
    @(negedge clk);
  endtask

  int seq [8];

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) dat[k] = '0;
`ifdef ARB_BURST_LOCK_EN
    seq = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    // Reset then idle
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data",  32'(bus.out_data),  32'd0);
    chk("rst out_sel",   32'(bus.out_sel),   32'd0);
    chk("rst in_ready",  32'(bus.in_ready),  32'd0);

    // Single requester 2, then idle holds data/sel, then pointer resumes at 3
    dat[2] = 4'hA;
    step(4'b0100, 1'b1, 1'b0);
    chk("single in_ready", 32'(bus.in_ready), 32'b0100);
    step(4'b0000, 1'b1, 1'b0);
    chk("single out_valid", 32'(bus.out_valid), 32'd1);
    chk("single out_data",  32'(bus.out_data),  32'hA);
    chk("single out_sel",   32'(bus.out_sel),   32'd2);
    step(4'b0000, 1'b1, 1'b0);
    chk("idle out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle out_sel",   32'(bus.out_sel),   32'd2);
    chk("idle out_data",  32'(bus.out_data),  32'hA);
    step(4'b1111, 1'b1, 1'b0);
    chk("after idle in_ready", 32'(bus.in_ready), 32'b1000);

    // All valid, full throughput
    step(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) dat[k] = 4'(k + 1);
    for (int i = 1; i <= 9; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      if (i <= 8) chk($sformatf("rr in_ready[%0d]", i), 32'(bus.in_ready), 32'(1 << seq[i-1]));
      if (i >= 2) begin
        chk($sformatf("rr out_sel[%0d]", i-1),  32'(bus.out_sel),  32'(seq[i-2]));
        chk($sformatf("rr out_data[%0d]", i-1), 32'(bus.out_data), 32'(seq[i-2] + 1));
      end
    end

    // Backpressure with out_sel=1 registered
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0010, 1'b1, 1'b0);
    chk("bp grant1 in_ready", 32'(bus.in_ready), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("bp stall in_ready", 32'(bus.in_ready), 32'b0000);
      chk("bp stall out_sel",  32'(bus.out_sel),  32'd1);
      chk("bp stall out_data", 32'(bus.out_data), 32'd2);
      chk("bp stall out_valid", 32'(bus.out_valid), 32'd1);
    end
    step(4'b1111, 1'b1, 1'b0);
    chk("bp release out_sel", 32'(bus.out_sel), 32'd1);
`ifdef ARB_BURST_LOCK_EN
    chk("bp release in_ready", 32'(bus.in_ready), 32'b0010);
    step(4'b0000, 1'b1, 1'b0);
    chk("bp next out_sel",  32'(bus.out_sel),  32'd1);
    chk("bp next out_data", 32'(bus.out_data), 32'd2);
`else
    chk("bp release in_ready", 32'(bus.in_ready), 32'b0100);
    step(4'b0000, 1'b1, 1'b0);
    chk("bp next out_sel",  32'(bus.out_sel),  32'd2);
    chk("bp next out_data", 32'(bus.out_data), 32'd3);
`endif

    // Reset mid-stream after grants 0,1
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0001, 1'b1, 1'b0);
    chk("mid g0 in_ready", 32'(bus.in_ready), 32'b0001);
    step(4'b0010, 1'b1, 1'b0);
    chk("mid g1 in_ready", 32'(bus.in_ready), 32'b0010);
    step(4'b1111, 1'b1, 1'b1);
    chk("mid rst in_ready", 32'(bus.in_ready), 32'b0000);
    chk("mid pre-rst out_sel", 32'(bus.out_sel), 32'd1);
    step(4'b1111, 1'b1, 1'b0);
    chk("mid post-rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid post-rst in_ready",  32'(bus.in_ready),  32'b0001);
    step(4'b0000, 1'b1, 1'b0);
    chk("mid post-rst out_sel",   32'(bus.out_sel),   32'd0);
    chk("mid post-rst out_valid", 32'(bus.out_valid), 32'd1);
    chk("mid post-rst out_data",  32'(bus.out_data),  32'd1);

    step(4'b0000, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one 4:1 data mux between requesters and registers the selected word onto a single valid/ready output.
- Computes the mux select (grant) each cycle and drives per-requester ready.
- Sits between independent producers and a shared downstream consumer.
- Output is one register stage; full throughput of one transfer per cycle.

Parameters:
- WIDTH, 4, data width of each requester and of the output.
- BURST_LEN, 4, max consecutive grants to one requester; used only with ARB_BURST_LOCK_EN; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  4  bit k = requester k has a word
- in_data0  input  WIDTH  requester 0 data
- in_data1  input  WIDTH  requester 1 data
- in_data2  input  WIDTH  requester 2 data
- in_data3  input  WIDTH  requester 3 data
- in_ready  output  4  one-hot or zero; bit k = word from k accepted this cycle
- out_valid  output  1  out_data holds a word
- out_data  output  WIDTH  registered selected word
- out_sel  output  2  index of requester that supplied out_data
- out_ready  input  1  downstream accepts when high with out_valid

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_sel=0, last_grant=3, so requester 0 has top priority first. Burst counter=0.
- load_en = !out_valid || out_ready. This is combinational.
- Winner: first k with in_valid[k]=1, scanning (last_grant+1) mod 4 upward with wrap (3->0).
- in_ready[winner] = load_en && |in_valid. All other in_ready bits are 0. in_ready never has more than one bit set. in_ready is 0 during rst.
- Transfer on requester k occurs when in_valid[k] && in_ready[k].
- On load_en with any valid, at the next edge:
  - out_data <= in_data[winner]
  - out_sel <= winner
  - out_valid <= 1
  - last_grant <= winner
- On load_en with no valid: out_valid <= 0. out_data, out_sel and last_grant hold.
- On !load_en (stall: out_valid=1, out_ready=0): all registers hold and in_ready=0. Requesters must hold valid/data; the arbiter does not require this for correctness.
- Latency: accepted word appears on out_data exactly 1 cycle after its in_ready cycle.
- Simultaneous out_ready and new request: the old word leaves and the new word loads in the same edge, with no bubble.
- Fairness: with all four valid continuously and out_ready=1, grant order is 0,1,2,3,0,...; each requester is served within 4 transfers.
- Reset mid-operation: any pending out_valid word is dropped. The next grant starts from requester 0.
- A requester dropping valid while not granted has no effect on the pointer.

Optional Feature:
- Macro: ARB_BURST_LOCK_EN
- Defined:
  - A 4-bit burst counter counts consecutive grants to last_grant.
  - On load_en, if in_valid[last_grant]=1 and count < BURST_LEN, last_grant wins again and count increments.
  - Otherwise the normal round-robin scan applies and count resets to 1 on the new grant.
  - If no valid, count is 0.
  - BURST_LEN=1 behaves identically to the undefined case.
- Undefined: no counter is present. Pure per-transfer round-robin; BURST_LEN is ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Single requester: in_valid=0100, in_data2=4'hA, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=4'hA, out_sel=2.
- All valid, out_ready=1, data k = 4'h1+k, 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data 1,2,3,4,1,2,3,4; in_ready one-hot every cycle.
- Backpressure: after out_valid=1 with out_sel=1, hold out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000, out_data/out_sel stable; on release, next grant is requester 2 and the word is loaded the following edge.
- Reset mid-stream: after grants 0,1, assert rst one cycle with in_valid=1111 -> out_valid=0; first post-reset grant is 0, not 2.
- ARB_BURST_LOCK_EN, BURST_LEN=2, in_valid=1111, out_ready=1 -> out_sel 0,0,1,1,2,2,3,3. Same stimulus without the macro -> 0,1,2,3,0,1,2,3.
